// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. It performs one radix-2
//               step per cycle over 32 cycles, then a single sign-fixup cycle,
//               so every operation has the same latency. It produces a
//               write-back strobe for the register file.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_start           - request a new op (taken when not busy)
//               i_flush           - abort in-flight op, no write-back
//               i_funct3          - RV32M operation select
//               i_rs1_data/rs2    - operands, sampled only at acceptance
//               i_rd_addr         - destination register
//               o_busy            - op in progress (CALC/FIX)
//               o_done            - one-cycle result-valid pulse
//               o_result/wb_addr  - result and destination, held until next done
//               o_wb_we           - done && wb_addr != 0
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_wb_addr,
  output logic            o_wb_we
);

  localparam logic [5:0] c_LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              w_accept;
  logic              w_finish;
  logic              w_busy;

  // Latched operation context
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_neg_lo;   // negate product (mul) or quotient (div)
  logic              r_neg_rem;  // negate remainder
  logic [5:0]        r_cnt;
  logic [XLEN-1:0]   r_opnd;     // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0] r_acc;      // mul: {partial, multiplier}; div: {rem, quot}

  // Output registers
  logic              r_done;
  logic              r_we;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_wb_addr;

  // --------------------------------------------------------------------------
  // Operand conditioning at acceptance
  // --------------------------------------------------------------------------
  logic            w_is_div;
  logic            w_sgn_a;
  logic            w_sgn_b;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_b_zero;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;

  assign w_is_div = i_funct3[2];
  // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
  // MUL is treated as unsigned: the low half of the product is sign-agnostic.
  assign w_sgn_a  = w_is_div ? ~i_funct3[0]
                             : (i_funct3[1:0] == 2'b01) || (i_funct3[1:0] == 2'b10);
  assign w_sgn_b  = w_is_div ? ~i_funct3[0] : (i_funct3[1:0] == 2'b01);
  assign w_a_neg  = w_sgn_a & i_rs1_data[XLEN-1];
  assign w_b_neg  = w_sgn_b & i_rs2_data[XLEN-1];
  assign w_a_mag  = w_a_neg ? (~i_rs1_data + 1'b1) : i_rs1_data;
  assign w_b_mag  = w_b_neg ? (~i_rs2_data + 1'b1) : i_rs2_data;
  assign w_b_zero = (i_rs2_data == '0);

  // --------------------------------------------------------------------------
  // Per-cycle iteration step
  // --------------------------------------------------------------------------
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [2*XLEN:0]   w_div_shift;
  logic [XLEN:0]     w_div_trial;
  logic [2*XLEN-1:0] w_div_next;

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]}
                    + {1'b0, (r_acc[0] ? r_opnd : {XLEN{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring division: shift {rem, quot} left, try subtracting the divisor
  // from the 33-bit partial remainder, keep it and set the quotient bit if
  // the difference did not go negative.
  assign w_div_shift = {r_acc, 1'b0};
  assign w_div_trial = w_div_shift[2*XLEN:XLEN] - {1'b0, r_opnd};
  assign w_div_next  = w_div_trial[XLEN] ? w_div_shift[2*XLEN-1:0]
                     : {w_div_trial[XLEN-1:0], w_div_shift[XLEN-1:1], 1'b1};

  // --------------------------------------------------------------------------
  // Sign fixup and result select
  // --------------------------------------------------------------------------
  // Divide by zero falls out of the restoring loop as quot=all-ones and
  // rem=|rs1|; the quotient negate is suppressed at acceptance and the
  // remainder takes rs1's sign, giving 0xFFFFFFFF and rs1. The signed
  // overflow case also falls out naturally: |0x80000000| / 1 = 0x80000000
  // with opposite-sign negation cancelled, remainder 0.
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_result;

  assign w_prod = r_neg_lo  ? (~r_acc + 1'b1) : r_acc;
  assign w_quot = r_neg_lo  ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_rem ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_result = w_prod[XLEN-1:0];
    case (r_op)
      3'b000:                 w_fix_result = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_result = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_result = w_quot;
      default:                w_fix_result = w_rem;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        // DONE accepts a new op just like IDLE for back-to-back issue.
        w_accept    = i_start & ~i_flush;
        w_state_nxt = w_accept ? S_CALC : S_IDLE;
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (i_flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_LAST_STEP) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_busy      = 1'b1;
        w_finish    = ~i_flush;
        w_state_nxt = i_flush ? S_IDLE : S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= 3'b000;
      r_rd      <= 5'd0;
      r_neg_lo  <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= 6'd0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_done    <= 1'b0;
      r_we      <= 1'b0;
      r_result  <= '0;
      r_wb_addr <= 5'd0;
    end else begin
      if (w_accept) begin
        r_op      <= i_funct3;
        r_rd      <= i_rd_addr;
        r_cnt     <= 6'd0;
        r_neg_rem <= w_a_neg;
        if (w_is_div) begin
          r_neg_lo <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
          r_opnd   <= w_b_mag;
          r_acc    <= {{XLEN{1'b0}}, w_a_mag};
        end else begin
          r_neg_lo <= w_a_neg ^ w_b_neg;
          r_opnd   <= w_a_mag;
          r_acc    <= {{XLEN{1'b0}}, w_b_mag};
        end
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + 6'd1;
        r_acc <= r_op[2] ? w_div_next : w_mul_next;
      end

      r_done <= w_finish;
      r_we   <= w_finish && (r_rd != 5'd0);
      if (w_finish) begin
        r_result  <= w_fix_result;
        r_wb_addr <= r_rd;
      end
    end
  end

  assign o_busy    = w_busy;
  assign o_done    = r_done;
  assign o_result  = r_result;
  assign o_wb_addr = r_wb_addr;
  assign o_wb_we   = r_we;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard testbench for muldiv_unit. Stimulus pushes the
//               hand-computed expected result, destination, write enable and
//               completion cycle; an independent monitor pops and compares on
//               every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_flush;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;
  logic [4:0]  o_wb_addr;
  logic        o_wb_we;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_flush    (i_flush),
    .i_funct3   (i_funct3),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_rd_addr  (i_rd_addr),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_wb_addr  (o_wb_addr),
    .o_wb_we    (o_wb_we)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  addr;
    logic        we;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'd0, o_done}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result",  o_result, e.res);
          chk("wb_addr", {27'd0, o_wb_addr}, {27'd0, e.addr});
          chk("wb_we",   {31'd0, o_wb_we}, {31'd0, e.we});
          chk("busy_at_done", {31'd0, o_busy}, 32'd0);
          chk("latency", cyc, e.at);
        end
      end
    end
  end

  // Called at a negedge: present one op for one cycle, then scramble inputs
  // so that any sampling outside acceptance would corrupt the result.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input bit push);
    exp_t e;
    i_funct3   = f3;
    i_rs1_data = a;
    i_rs2_data = b;
    i_rd_addr  = rd;
    i_start    = 1'b1;
    if (push) begin
      e.res  = exp;
      e.addr = rd;
      e.we   = (rd != 5'd0);
      e.at   = cyc + 34;
      sb.push_back(e);
    end
    @(negedge clk);
    i_start    = 1'b0;
    i_funct3   = 3'b010;
    i_rs1_data = 32'hA5A5_A5A5;
    i_rs2_data = 32'h0000_0000;
    i_rd_addr  = 5'd31;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp);
    issue(f3, a, b, rd, exp, 1'b1);
    wait_drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    rst        = 1'b1;
    i_start    = 1'b1;  // reset must win over start
    i_flush    = 1'b0;
    i_funct3   = 3'b000;
    i_rs1_data = 32'd1;
    i_rs2_data = 32'd1;
    i_rd_addr  = 5'd1;
    repeat (3) @(negedge clk);
    chk("rst_busy",    {31'd0, o_busy},    32'd0);
    chk("rst_done",    {31'd0, o_done},    32'd0);
    chk("rst_result",  o_result,           32'd0);
    chk("rst_wb_we",   {31'd0, o_wb_we},   32'd0);
    chk("rst_wb_addr", {27'd0, o_wb_addr}, 32'd0);
    i_start = 1'b0;
    rst     = 1'b0;
    @(negedge clk);

    // MUL 7 * -3 with busy window checks
    n = cyc;
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1);
    chk("busy_first", {31'd0, o_busy}, 32'd1);
    while (cyc < n + 33) @(negedge clk);
    chk("busy_last", {31'd0, o_busy}, 32'd1);
    chk("no_early_done", {31'd0, o_done}, 32'd0);
    wait_drain();

    run(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000); // MULH
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE); // MULHU
    run(3'b010, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF); // MULHSU
    run(3'b001, 32'hFFFF_FFFF, 32'd1,         5'd4,  32'hFFFF_FFFF); // MULH -1*1
    run(3'b000, 32'h1234_5678, 32'h10,        5'd19, 32'h2345_6780); // MUL
    run(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD); // DIV -7/2
    run(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF); // REM -7/2
    run(3'b101, 32'd100,       32'd0,         5'd12, 32'hFFFF_FFFF); // DIVU /0
    run(3'b111, 32'd100,       32'd0,         5'd13, 32'd100);       // REMU /0
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000); // DIV ovf
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0);         // REM ovf
    run(3'b100, 32'hFFFF_FFF9, 32'd0,         5'd16, 32'hFFFF_FFFF); // DIV -7/0
    run(3'b110, 32'hFFFF_FFF9, 32'd0,         5'd17, 32'hFFFF_FFF9); // REM -7/0
    run(3'b101, 32'hFFFF_FFF9, 32'd2,         5'd18, 32'h7FFF_FFFC); // DIVU
    run(3'b110, 32'd7,         32'hFFFF_FFFE, 5'd20, 32'd1);         // REM 7/-2

    // Start while busy is ignored; start in DONE is accepted back-to-back
    n = cyc;
    issue(3'b101, 32'd10, 32'd3, 5'd7, 32'd3, 1'b1);
    while (cyc < n + 10) @(negedge clk);
    issue(3'b000, 32'd5, 32'd6, 5'd9, 32'd0, 1'b0);
    while (cyc < n + 34) @(negedge clk);
    chk("b2b_done_cycle", {31'd0, o_done}, 32'd1);
    issue(3'b111, 32'd10, 32'd3, 5'd8, 32'd1, 1'b1);
    wait_drain();

    // Reset mid-operation
    n = cyc;
    issue(3'b100, 32'd100, 32'd7, 5'd3, 32'd0, 1'b0);
    while (cyc < n + 15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",   {31'd0, o_busy}, 32'd0);
    chk("midrst_done",   {31'd0, o_done}, 32'd0);
    chk("midrst_result", o_result,        32'd0);
    repeat (40) @(negedge clk);

    // rd=0: executes, but no write enable
    run(3'b000, 32'd3, 32'd4, 5'd0, 32'd12);

    // Flush mid-operation keeps previous result
    n = cyc;
    issue(3'b100, 32'd100, 32'd7, 5'd6, 32'd0, 1'b0);
    while (cyc < n + 15) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush_busy",   {31'd0, o_busy}, 32'd0);
    chk("flush_done",   {31'd0, o_done}, 32'd0);
    chk("flush_result", o_result,        32'd12);
    repeat (40) @(negedge clk);

    // Flush in DONE: done stands, simultaneous start suppressed
    n = cyc;
    issue(3'b101, 32'd9, 32'd3, 5'd4, 32'd3, 1'b1);
    while (cyc < n + 34) @(negedge clk);
    i_flush    = 1'b1;
    i_start    = 1'b1;
    i_funct3   = 3'b000;
    i_rs1_data = 32'd2;
    i_rs2_data = 32'd2;
    i_rd_addr  = 5'd9;
    @(negedge clk);
    i_flush = 1'b0;
    i_start = 1'b0;
    chk("flush_done_no_accept", {31'd0, o_busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_done_result", o_result, 32'd3);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
